// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad matrix and hands debounced key codes
// to a consumer over a valid/ack handshake.
//   clk, rst_n : single clock, asynchronous active-low reset
//   row        : active-low row inputs (pulled up, asynchronous to clk)
//   col        : active-low one-hot column drive
//   key_code   : {row_idx, col_idx} of the pending key, stable while key_valid=1
//   key_valid  : key pending, held until key_ack
//   key_ack    : consumer accepts the pending key
//   key_held   : debounced key currently down
//   overrun    : 1-cycle pulse when a new key is debounced while one is still pending
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  // True when exactly one row line is pulled low.
  function automatic logic one_low(input logic [3:0] r);
    logic [3:0] n;
    n = ~r;
    return (n != 4'd0) && ((n & (n - 4'd1)) == 4'd0);
  endfunction

  // Index of the single low row line.
  function automatic logic [1:0] low_idx(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Column index to active-low one-hot drive.
  function automatic logic [3:0] col_of(input logic [1:0] idx);
    logic [3:0] c;
    case (idx)
      2'd0:    c = 4'b1110;
      2'd1:    c = 4'b1101;
      2'd2:    c = 4'b1011;
      default: c = 4'b0111;
    endcase
    return c;
  endfunction

  state_t        state, state_n;
  logic [3:0]    row_m, row_s;
  logic [DW-1:0] dwell_cnt, dwell_n;
  logic [1:0]    col_idx, col_idx_n;
  logic [1:0]    row_idx, row_idx_n;
  logic [3:0]    pat, pat_n;
  logic [CW-1:0] deb_cnt, deb_n;
  logic [CW-1:0] rel_cnt, rel_n;
  logic [3:0]    col_n, key_code_n;
  logic          key_valid_n, key_held_n, overrun_n;
  logic          sample, enter_pressed;

  // Two-flop synchronizer for the asynchronous row pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_m <= 4'b1111;
      row_s <= 4'b1111;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  assign sample = (dwell_cnt == DWELL_LAST);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      dwell_cnt <= '0;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      pat       <= 4'b1111;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      col       <= 4'b1110;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      dwell_cnt <= dwell_n;
      col_idx   <= col_idx_n;
      row_idx   <= row_idx_n;
      pat       <= pat_n;
      deb_cnt   <= deb_n;
      rel_cnt   <= rel_n;
      col       <= col_n;
      key_code  <= key_code_n;
      key_valid <= key_valid_n;
      key_held  <= key_held_n;
      overrun   <= overrun_n;
    end
  end

  // Next-state, scan/debounce and handshake logic.
  always_comb begin
    state_n       = state;
    dwell_n       = sample ? '0 : dwell_cnt + DW'(1);
    col_idx_n     = col_idx;
    row_idx_n     = row_idx;
    pat_n         = pat;
    deb_n         = deb_cnt;
    rel_n         = rel_cnt;
    key_code_n    = key_code;
    key_valid_n   = key_valid;
    overrun_n     = 1'b0;
    enter_pressed = 1'b0;

    if (key_ack && key_valid) key_valid_n = 1'b0;

    case (state)
      SCAN: begin
        if (sample) begin
          if (one_low(row_s)) begin
            row_idx_n = low_idx(row_s);
            pat_n     = row_s;
            deb_n     = CW'(1);
            state_n   = DEBOUNCE;
          end else begin
            col_idx_n = col_idx + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (sample) begin
          if (row_s == pat) begin
            if (deb_cnt == DEB_LAST) begin
              state_n       = PRESSED;
              rel_n         = '0;
              enter_pressed = 1'b1;
            end else begin
              deb_n = deb_cnt + CW'(1);
            end
          end else begin
            state_n   = SCAN;
            deb_n     = '0;
            col_idx_n = col_idx + 2'd1;
          end
        end
      end
      PRESSED: begin
        if (sample) begin
          if (row_s == 4'b1111) begin
            if (rel_cnt == DEB_LAST) begin
              state_n   = SCAN;
              rel_n     = '0;
              col_idx_n = col_idx + 2'd1;
            end else begin
              rel_n = rel_cnt + CW'(1);
            end
          end else begin
            rel_n = '0;
          end
        end
      end
      default: state_n = SCAN;
    endcase

    // A pending, un-acked key blocks the new one and flags overrun instead.
    if (enter_pressed) begin
      if (key_valid && !key_ack) begin
        overrun_n = 1'b1;
      end else begin
        key_code_n  = {row_idx, col_idx};
        key_valid_n = 1'b1;
      end
    end

    key_held_n = (state_n == PRESSED);
    col_n      = col_of(col_idx_n);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a small keypad matrix model.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_held;
  logic       overrun;

  logic [15:0] keys = 16'd0;   // bit r*4+c = key at row r, column c is down
  int checks = 0;
  int errors = 0;
  int ev_cnt = 0;
  logic kv_d = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_ack(key_ack), .key_held(key_held), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Matrix model: a row reads low if a pressed key sits on a driven-low column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Count rising edges of key_valid.
  always @(posedge clk) begin
    kv_d   <= key_valid;
    ev_cnt <= ev_cnt + ((key_valid && !kv_d) ? 1 : 0);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait up to maxc cycles for signal (0 key_valid,1 key_held,2 overrun) to equal val.
  task automatic wait_sig(input string tag, input int which, input logic val, input int maxc);
    logic hit;
    logic s;
    hit = 1'b0;
    for (int i = 0; i < maxc && !hit; i++) begin
      step(1);
      s = (which == 0) ? key_valid : (which == 1) ? key_held : overrun;
      if (s === val) hit = 1'b1;
    end
    chk(tag, {7'd0, hit}, 8'd1);
  endtask

  task automatic ack_once();
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
  endtask

  initial begin
    int ev0;
    int tmp;
    logic seen0;
    logic [3:0] rot [4];
    rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011; rot[3] = 4'b0111;

    // 1: reset and idle column rotation
    step(3);
    rst_n = 1'b1;
    step(6);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_col", 8'(col), 8'(4'b1110));
    chk("rst_valid", 8'(key_valid), 8'd0);
    chk("rst_held", 8'(key_held), 8'd0);
    chk("rst_code", 8'(key_code), 8'd0);
    step(2);
    rst_n = 1'b1;
    for (int p = 1; p <= 16; p++) begin
      step(1);
      tmp = (p / 4) % 4;
      chk($sformatf("rot_p%0d", p), 8'(col), 8'(rot[tmp]));
    end

    // 2: clean press row1/col2
    keys = 16'h0040;
    wait_sig("press6_valid", 0, 1'b1, 60);
    chk("press6_code", 8'(key_code), 8'h06);
    chk("press6_held", 8'(key_held), 8'd1);
    step(8);
    chk("press6_colfrozen", 8'(col), 8'(4'b1011));
    ack_once();
    chk("ack_clears", 8'(key_valid), 8'd0);
    keys = 16'h0000;
    wait_sig("rel6_held", 1, 1'b0, 40);

    // 3: bounce then stable hold
    step(8);
    ev0 = ev_cnt;
    for (int i = 0; i < 7; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      step(3);
    end
    chk("bounce_no_event", 8'(ev_cnt - ev0), 8'd0);
    chk("bounce_no_valid", 8'(key_valid), 8'd0);
    keys = 16'h0040;
    wait_sig("bounce_valid", 0, 1'b1, 60);
    chk("bounce_code", 8'(key_code), 8'h06);
    step(20);
    chk("bounce_one_event", 8'(ev_cnt - ev0), 8'd1);

    // 4: second key without ack -> overrun
    keys = 16'h0000;
    wait_sig("rel_b_held", 1, 1'b0, 40);
    keys = 16'h1000;
    wait_sig("overrun_pulse", 2, 1'b1, 80);
    chk("overrun_code", 8'(key_code), 8'h06);
    chk("overrun_valid", 8'(key_valid), 8'd1);
    chk("overrun_held", 8'(key_held), 8'd1);
    step(1);
    chk("overrun_1cyc", 8'(overrun), 8'd0);
    ack_once();
    chk("ack2_clears", 8'(key_valid), 8'd0);
    keys = 16'h0000;
    wait_sig("rel_c_held", 1, 1'b0, 40);
    keys = 16'h1000;
    wait_sig("pressC_valid", 0, 1'b1, 60);
    chk("pressC_code", 8'(key_code), 8'h0C);
    ack_once();
    keys = 16'h0000;
    wait_sig("relC_held", 1, 1'b0, 40);

    // 5: two keys in one column are ignored; long hold gives one event
    step(4);
    ev0 = ev_cnt;
    keys = 16'h0044;
    seen0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (col == 4'b1110) seen0 = 1'b1;
    end
    chk("multi_no_event", 8'(ev_cnt - ev0), 8'd0);
    chk("multi_held", 8'(key_held), 8'd0);
    chk("multi_scanning", 8'(seen0), 8'd1);
    keys = 16'h0040;
    step(60);
    chk("hold_one_event", 8'(ev_cnt - ev0), 8'd1);
    chk("hold_code", 8'(key_code), 8'h06);
    chk("hold_held", 8'(key_held), 8'd1);
    keys = 16'h0000;
    step(8);
    chk("release_held_early", 8'(key_held), 8'd1);
    step(7);
    chk("release_held_late", 8'(key_held), 8'd0);
    ack_once();

    // 6: reset while pressed, key re-reported once
    keys = 16'h0040;
    wait_sig("pre_rst_held", 1, 1'b1, 60);
    #3 rst_n = 1'b0;
    #1;
    chk("rstp_valid", 8'(key_valid), 8'd0);
    chk("rstp_held", 8'(key_held), 8'd0);
    chk("rstp_code", 8'(key_code), 8'd0);
    chk("rstp_col", 8'(col), 8'(4'b1110));
    step(2);
    ev0 = ev_cnt;
    rst_n = 1'b1;
    wait_sig("rerep_valid", 0, 1'b1, 60);
    chk("rerep_code", 8'(key_code), 8'h06);
    step(30);
    chk("rerep_one_event", 8'(ev_cnt - ev0), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
